seq_flag_tracker: RTL and testbench
===================================

// Module: seq_flag_tracker
// PURPOSE
//  Parametrised ordered-press tracker for the selecting machine. N one-cycle button
//  pulses must arrive in strict MSB-to-LSB order; each accepted press clears its flag.
//  Adds over the fixed 7-bit version: generic width, progress count, completion pulse,
//  wrong-order error handling with hold-off, software clear, and an optional inactivity
//  timeout. Sits between the button debouncer/pulse generator and the display/selection logic.
// PARAMETERS
//  N           7    number of channels (buttons/flags), 2..32
//  STRICT      1    1: wrong-order press aborts to ERROR; 0: wrong presses ignored
//  ERR_HOLD    8    cycles ERROR is held before returning to IDLE, >=1
//  TIMEOUT_CYC 50_000_000  inactivity limit in ARMED (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-low
//  BTN_pulse  in   N         one-cycle press pulses, bit N-1 expected first
//  clr        in   1         synchronous sequence clear, active-high
//  flag       out  N         1 = not yet pressed, 0 = accepted
//  stage      out  SW        accepted-press count 0..N, SW = $clog2(N+1)
//  done       out  1         one-cycle pulse on final accepted press
//  err        out  1         high throughout ERROR
//  timeout    out  1         one-cycle pulse on inactivity abort
// BEHAVIOUR
//  - Reset: rst==0 at posedge -> flag=all 1, stage=0, done=0, err=0, timeout=0,
//    state=IDLE, err/timeout counters=0. Reset has priority over everything.
//  - States: IDLE (stage 0), ARMED (0<stage<N), DONE (stage N), ERROR.
//  - Expected index e = N-1-stage. Valid = BTN_pulse[e]. Wrong = any other bit set.
//  - Latency: press sampled at edge k -> flag/stage/done updated at edge k+1 output.
//  - IDLE/ARMED, priority order per cycle:
//      clr -> IDLE, flags all 1, stage 0;
//      else STRICT && Wrong -> ERROR, flags all 1, stage 0, err=1 (even if Valid too);
//      else Valid -> flag[e]=0, stage+1; IDLE->ARMED; if stage+1==N -> DONE, done=1 one cycle;
//      else hold. STRICT=0: Wrong bits ignored, Valid accepted alongside them.
//  - Re-press of an already-cleared bit counts as Wrong.
//  - DONE: flags all 0, stage=N held; presses ignored; exit only via clr (-> IDLE) or reset.
//  - ERROR: err=1 for exactly ERR_HOLD cycles, presses ignored, then IDLE with err=0.
//    clr during ERROR -> IDLE next cycle, err=0, hold counter cleared.
//  - done and timeout are never asserted in the same cycle; both default 0 each cycle.
//  - stage arithmetic: SW-bit unsigned, never exceeds N, never wraps.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: idle counter ($clog2(TIMEOUT_CYC) bits) runs only in ARMED,
//   clears on every accepted press and on entry to ARMED; when it reaches TIMEOUT_CYC-1
//   without a Valid press -> IDLE, flags all 1, stage 0, timeout=1 for one cycle.
//   Valid press in the terminal-count cycle wins (accepted, no timeout). clr wins over timeout.
//  SEQ_TIMEOUT_EN undefined: no counter synthesised, timeout tied 0, ARMED waits forever.
// TESTING (N=7, STRICT=1, ERR_HOLD=4, TIMEOUT_CYC=16 unless noted)
//  1 rst=0 2 cycles, release -> flag=7'h7F, stage=0, done=err=timeout=0.
//  2 pulses bit6,5,4,3,2,1,0 spaced 3 cycles -> flag steps 3F,1F,0F,07,03,01,00; done=1 one cycle after bit0 pulse; stage=7.
//  3 bits 6,5 accepted then bit3 -> next cycle flag=7F, stage=0, err=1 for 4 cycles, then IDLE; presses during ERROR ignored.
//  4 STRICT=0: bits6,5 then BTN_pulse=7'b0011000 -> flag=0F (bit4 accepted, bit3 ignored), no err.
//  5 SEQ_TIMEOUT_EN: bit6 then idle 16 cycles -> timeout pulse, flag=7F; repeat with bit5 at cycle 15 -> accepted, no timeout.
//  6 clr with bit6 pulse same cycle in IDLE -> stays 7F; rst=0 mid-ARMED (flag=1F) -> 7F next cycle.

Source files
------------

// File: rtl/seq_flag_tracker.sv
// Ordered-press tracker: N one-cycle button pulses must arrive MSB first; each accepted press clears its flag.
// Optional inactivity timeout in ARMED is built only when SEQ_TIMEOUT_EN is defined.
module seq_flag_tracker #(
  parameter int N           = 7,
  parameter int STRICT      = 1,
  parameter int ERR_HOLD    = 8,
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int SW         = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  BTN_pulse,
  input  logic          clr,
  output logic [N-1:0]  flag,
  output logic [SW-1:0] stage,
  output logic          done,
  output logic          err,
  output logic          timeout
);

  localparam int EW = $clog2(ERR_HOLD + 1);
  localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  flag_q, flag_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [N-1:0]  exp_mask;
  logic          valid;
  logic          wrong;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // One-hot mask of the bit expected next; becomes zero once stage reaches N.
  assign exp_mask = MSB_MASK >> stage_q;
  assign valid    = |(BTN_pulse & exp_mask);
  assign wrong    = |(BTN_pulse & ~exp_mask);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    stage_d   = stage_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_cnt_d = err_cnt_q;
`ifdef SEQ_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif

    unique case (state_q)
      S_IDLE, S_ARMED: begin
        if (clr) begin
          state_d = S_IDLE;
          flag_d  = '1;
          stage_d = '0;
        end else if ((STRICT != 0) && wrong) begin
          state_d   = S_ERROR;
          flag_d    = '1;
          stage_d   = '0;
          err_cnt_d = '0;
        end else if (valid) begin
          flag_d  = flag_q & ~exp_mask;
          stage_d = stage_q + SW'(1);
`ifdef SEQ_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if (stage_q == SW'(N - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ARMED;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (state_q == S_ARMED) begin
          if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d   = S_IDLE;
            flag_d    = '1;
            stage_d   = '0;
            timeout_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end
`endif
      end

      S_DONE: begin
        if (clr) begin
          state_d = S_IDLE;
          flag_d  = '1;
          stage_d = '0;
        end
      end

      S_ERROR: begin
        if (clr || (err_cnt_q == EW'(ERR_HOLD - 1))) begin
          state_d   = S_IDLE;
          err_cnt_d = '0;
        end else begin
          err_cnt_d = err_cnt_q + EW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      flag_q    <= '1;
      stage_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      flag_q    <= flag_d;
      stage_q   <= stage_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
`ifdef SEQ_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign flag    = flag_q;
  assign stage   = stage_q;
  assign done    = done_q;
  assign err     = (state_q == S_ERROR);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_seq_flag_tracker.sv
// Scoreboard bench for seq_flag_tracker: a strict instance and a non-strict instance share stimulus.
// Each driven cycle pushes hand-computed expected outputs; a monitor pops and compares after every edge.
module tb_seq_flag_tracker;

  logic       clk;
  logic       rst;
  logic [6:0] btn;
  logic       clr;

  logic [6:0] flag_s, flag_l;
  logic [2:0] stage_s, stage_l;
  logic       done_s, done_l, err_s, err_l, to_s, to_l;

  seq_flag_tracker #(.N(7), .STRICT(1), .ERR_HOLD(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .BTN_pulse(btn), .clr(clr),
    .flag(flag_s), .stage(stage_s), .done(done_s), .err(err_s), .timeout(to_s)
  );

  seq_flag_tracker #(.N(7), .STRICT(0), .ERR_HOLD(4), .TIMEOUT_CYC(16)) dut_lax (
    .clk(clk), .rst(rst), .BTN_pulse(btn), .clr(clr),
    .flag(flag_l), .stage(stage_l), .done(done_l), .err(err_l), .timeout(to_l)
  );

  typedef struct {
    int         id;
    logic       sel;
    logic [6:0] flag;
    logic [2:0] stage;
    logic       done;
    logic       err;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic [6:0] b, input logic c, input logic r, input logic sel,
                      input logic [6:0] ef, input logic [2:0] es,
                      input logic ed, input logic ee, input logic et);
    exp_t e;
    @(negedge clk);
    btn = b;
    clr = c;
    rst = r;
    e.id = step_no; e.sel = sel; e.flag = ef; e.stage = es;
    e.done = ed; e.err = ee; e.to = et;
    sb.push_back(e);
    step_no++;
  endtask

  task automatic press(input int bit_i, input logic sel, input logic [6:0] ef,
                       input logic [2:0] es, input logic ed, input logic ee);
    logic [6:0] b;
    b = 7'(1 << bit_i);
    step(b, 1'b0, 1'b1, sel, ef, es, ed, ee, 1'b0);
  endtask

  task automatic idle(input int n, input logic sel, input logic [6:0] ef,
                      input logic [2:0] es, input logic ee);
    for (int k = 0; k < n; k++) step(7'h00, 1'b0, 1'b1, sel, ef, es, 1'b0, ee, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
          check("flag",    e.id, 32'(flag_s),  32'(e.flag));
          check("stage",   e.id, 32'(stage_s), 32'(e.stage));
          check("done",    e.id, 32'(done_s),  32'(e.done));
          check("err",     e.id, 32'(err_s),   32'(e.err));
          check("timeout", e.id, 32'(to_s),    32'(e.to));
        end else begin
          check("lax_flag",  e.id, 32'(flag_l),  32'(e.flag));
          check("lax_stage", e.id, 32'(stage_l), 32'(e.stage));
          check("lax_done",  e.id, 32'(done_l),  32'(e.done));
          check("lax_err",   e.id, 32'(err_l),   32'(e.err));
        end
      end
    end
  end

  initial begin : stimulus
    logic [6:0] f;
    rst = 1'b0;
    btn = 7'h00;
    clr = 1'b0;

    // Reset held two cycles, then released.
    step(7'h00, 1'b0, 1'b0, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    step(7'h00, 1'b0, 1'b0, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 7'h7F, 3'd0, 1'b0);

    // Full ordered sequence, pulses spaced three cycles apart.
    for (int i = 6; i >= 0; i--) begin
      f = 7'((1 << i) - 1);
      press(i, 1'b0, f, 3'(7 - i), (i == 0), 1'b0);
      idle(2, 1'b0, f, 3'(7 - i), 1'b0);
    end
    // DONE ignores presses and leaves only on clr.
    press(6, 1'b0, 7'h00, 3'd7, 1'b0, 1'b0);
    press(0, 1'b0, 7'h00, 3'd7, 1'b0, 1'b0);
    step(7'h00, 1'b1, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);

    // Wrong order: 6, 5, then 3 -> ERROR for four cycles, presses ignored.
    press(6, 1'b0, 7'h3F, 3'd1, 1'b0, 1'b0);
    press(5, 1'b0, 7'h1F, 3'd2, 1'b0, 1'b0);
    press(3, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b1);
    press(6, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b1);
    press(6, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b1);
    idle(1, 1'b0, 7'h7F, 3'd0, 1'b1);
    idle(1, 1'b0, 7'h7F, 3'd0, 1'b0);
    press(6, 1'b0, 7'h3F, 3'd1, 1'b0, 1'b0);

    // Re-press of a cleared bit is wrong; clr during ERROR exits next cycle.
    press(6, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b1);
    step(7'h00, 1'b1, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    press(6, 1'b0, 7'h3F, 3'd1, 1'b0, 1'b0);

    // Valid bit together with a wrong bit still aborts in strict mode.
    step(7'b0100001, 1'b0, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0, 7'h7F, 3'd0, 1'b1);
    idle(1, 1'b0, 7'h7F, 3'd0, 1'b0);

    // clr beats a simultaneous valid press; reset mid-ARMED restores all flags.
    step(7'b1000000, 1'b1, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    press(6, 1'b0, 7'h3F, 3'd1, 1'b0, 1'b0);
    press(5, 1'b0, 7'h1F, 3'd2, 1'b0, 1'b0);
    step(7'b0010000, 1'b0, 1'b0, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 7'h7F, 3'd0, 1'b0);

    // Non-strict instance: wrong bits ignored, valid accepted alongside them.
    step(7'h00, 1'b0, 1'b0, 1'b1, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    press(6, 1'b1, 7'h3F, 3'd1, 1'b0, 1'b0);
    press(5, 1'b1, 7'h1F, 3'd2, 1'b0, 1'b0);
    step(7'b0011000, 1'b0, 1'b1, 1'b1, 7'h0F, 3'd3, 1'b0, 1'b0, 1'b0);
    press(0, 1'b1, 7'h0F, 3'd3, 1'b0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
    // Inactivity abort after 16 idle cycles in ARMED, then a press in the terminal cycle wins.
    step(7'h00, 1'b0, 1'b0, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0);
    press(6, 1'b0, 7'h3F, 3'd1, 1'b0, 1'b0);
    idle(15, 1'b0, 7'h3F, 3'd1, 1'b0);
    step(7'h00, 1'b0, 1'b1, 1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0, 7'h7F, 3'd0, 1'b0);
    press(6, 1'b0, 7'h3F, 3'd1, 1'b0, 1'b0);
    idle(15, 1'b0, 7'h3F, 3'd1, 1'b0);
    press(5, 1'b0, 7'h1F, 3'd2, 1'b0, 1'b0);
    idle(3, 1'b0, 7'h1F, 3'd2, 1'b0);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
